// File: rtl/reg_write_ctrl_pkg.sv
// Shared types for the register write-back controller:
// the {valid, rd} stage record and the one-hot index decode.
package reg_write_ctrl_pkg;

  // Widest supported register index (32 architectural registers)
  localparam int MAX_AW = 5;

  typedef logic [MAX_AW-1:0] ridx_t;

  typedef struct packed {
    logic  valid;
    ridx_t rd;
  } wb_stage_t;

  // Bit i of the one-hot decode of idx
  function automatic logic onehot_bit(
    input ridx_t idx,
    input int    i
  );
    return idx == ridx_t'(i);
  endfunction

endpackage

// File: rtl/reg_wb_pipe.sv
// LAT-deep {valid, rd} shift pipeline with flush, plus a
// population count of the valid stages.
module reg_wb_pipe
  import reg_write_ctrl_pkg::*;
#(
  parameter  int LAT = 2,
  localparam int CW  = $clog2(LAT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  wb_stage_t       in_i,
  output wb_stage_t       out_o,
  output logic [CW-1:0]   cnt_o
);

  wb_stage_t st_q [LAT];
  wb_stage_t st_d [LAT];

  always_comb begin
    st_d[0] = in_i;
    for (int i = 1; i < LAT; i++) begin
      st_d[i] = st_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      st_q <= '{default: '0};
    end else begin
      st_q <= st_d;
    end
  end

  assign out_o = st_q[LAT-1];

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < LAT; i++) begin
      cnt_o = cnt_o + CW'(st_q[i].valid);
    end
  end

endmodule

// File: rtl/reg_write_ctrl.sv
// Register write-back controller: issue hazard check, scoreboard, one-hot reg_en.
// Define REG_WRITE_CTRL_ZERO_LOCK_EN to hardwire register 0 (never written).
module reg_write_ctrl
  import reg_write_ctrl_pkg::*;
#(
  parameter  int NUM_REGS = 4,
  parameter  int LAT      = 2,
  localparam int AW       = $clog2(NUM_REGS),
  localparam int CW       = $clog2(LAT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [AW-1:0]       issue_rd,
  input  logic [AW-1:0]       issue_rs1,
  input  logic [AW-1:0]       issue_rs2,
  input  logic                issue_bne,
  input  logic                flush,
  output logic [NUM_REGS-1:0] reg_en,
  output logic                wb_valid,
  output logic [AW-1:0]       wb_rd,
  output logic [NUM_REGS-1:0] pending,
  output logic [CW-1:0]       inflight_cnt
);

  ridx_t               rd_x;
  wb_stage_t           st_in;
  wb_stage_t           st_out;
  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_d;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] set_v;
  logic [NUM_REGS-1:0] zmask;
  logic                accept;
  logic                wr_en;
  logic                rd_ok;

  assign rd_x = ridx_t'(issue_rd);

`ifdef REG_WRITE_CTRL_ZERO_LOCK_EN
  assign rd_ok = |issue_rd;
  assign zmask = NUM_REGS'(1);
`else
  assign rd_ok = 1'b1;
  assign zmask = '0;
`endif

  // Retirement is suppressed in flush and reset cycles
  assign wb_valid = st_out.valid & ~flush & ~rst;

  always_comb begin
    reg_en = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_en[i] = wb_valid & onehot_bit(st_out.rd, i);
    end
  end

  assign wb_rd = wb_valid ? st_out.rd[AW-1:0] : '0;

  // A register retiring this cycle is already free
  assign busy = pend_q & ~reg_en & ~zmask;

  assign issue_ready = ~flush
                     & ~busy[issue_rs1]
                     & ~busy[issue_rs2]
                     & (issue_bne | ~busy[issue_rd]);

  assign accept = issue_valid & issue_ready;
  assign wr_en  = accept & ~issue_bne & rd_ok;

  assign st_in = '{valid: wr_en, rd: rd_x};

  always_comb begin
    set_v = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      set_v[i] = wr_en & onehot_bit(rd_x, i);
    end
  end

  assign pend_d = (pend_q & ~reg_en) | set_v;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pending = pend_q;

  reg_wb_pipe #(
    .LAT (LAT)
  ) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .in_i    (st_in),
    .out_o   (st_out),
    .cnt_o   (inflight_cnt)
  );

endmodule

// File: tb/tb_reg_write_ctrl.sv
// Bench for reg_write_ctrl: directed scenarios, then random traffic
// checked against a retirement-schedule model; plus an 8-reg/LAT=3 instance.
module tb_reg_write_ctrl;

  localparam int NR = 4;
  localparam int L  = 2;
  localparam int AW = 2;
  localparam int CW = 2;
`ifdef REG_WRITE_CTRL_ZERO_LOCK_EN
  localparam bit ZL = 1'b1;
`else
  localparam bit ZL = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, issue_valid, issue_ready, issue_bne, flush, wb_valid;
  logic [AW-1:0] issue_rd, issue_rs1, issue_rs2, wb_rd;
  logic [NR-1:0] reg_en, pending;
  logic [CW-1:0] inflight_cnt;

  logic       rst2, v2, rdy2, bne2, flush2, wbv2;
  logic [2:0] rd2, rs1_2, rs2_2, wbrd2;
  logic [7:0] en2, pend2;
  logic [1:0] cnt2;

  reg_write_ctrl #(.NUM_REGS(NR), .LAT(L)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_bne(issue_bne), .flush(flush),
    .reg_en(reg_en), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .pending(pending), .inflight_cnt(inflight_cnt)
  );

  reg_write_ctrl #(.NUM_REGS(8), .LAT(3)) dut8 (
    .clk(clk), .rst(rst2),
    .issue_valid(v2), .issue_ready(rdy2),
    .issue_rd(rd2), .issue_rs1(rs1_2), .issue_rs2(rs2_2),
    .issue_bne(bne2), .flush(flush2),
    .reg_en(en2), .wb_valid(wbv2), .wb_rd(wbrd2),
    .pending(pend2), .inflight_cnt(cnt2)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Each accepted write is remembered with the cycle it must retire in
  typedef struct {
    int rd;
    int due;
  } rec_t;
  rec_t q[$];

  logic          obs_ready, obs_wbv;
  logic [NR-1:0] obs_en, obs_pend;
  logic [AW-1:0] obs_rd;
  logic [CW-1:0] obs_cnt;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input int rd, input int rs1,
                      input int rs2, input bit bne, input bit fl,
                      input bit r);
    logic [NR-1:0] epend, ebusy, een;
    int   erd;
    bit   ewbv, erdy;
    rec_t nq[$];
    issue_valid = v;
    issue_rd    = AW'(rd);
    issue_rs1   = AW'(rs1);
    issue_rs2   = AW'(rs2);
    issue_bne   = bne;
    flush       = fl;
    rst         = r;
    #1;
    epend = '0;
    een   = '0;
    ewbv  = 1'b0;
    erd   = 0;
    foreach (q[k]) begin
      epend[q[k].rd] = 1'b1;
      if (q[k].due == cyc && !fl && !r) begin
        ewbv = 1'b1;
        erd  = q[k].rd;
        een[q[k].rd] = 1'b1;
      end
    end
    ebusy = epend & ~een;
    erdy  = !fl && !ebusy[rs1] && !ebusy[rs2] && (bne || !ebusy[rd]);
    obs_ready = issue_ready;
    obs_wbv   = wb_valid;
    obs_en    = reg_en;
    obs_pend  = pending;
    obs_rd    = wb_rd;
    obs_cnt   = inflight_cnt;
    chk("wb_valid", wb_valid, ewbv);
    chk("reg_en", reg_en, een);
    chk("wb_rd", wb_rd, erd);
    chk("pending", pending, epend);
    chk("inflight_cnt", inflight_cnt, q.size());
    if (!r) chk("issue_ready", issue_ready, erdy);
    if (r || fl) begin
      q.delete();
    end else begin
      foreach (q[k]) if (q[k].due != cyc) nq.push_back(q[k]);
      q = nq;
    end
    if (v && erdy && !r && !bne && !(ZL && rd == 0))
      q.push_back(rec_t'{rd: rd, due: cyc + L});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_bne = 1'b0; flush = 1'b0;
    issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
    rst2 = 1'b1; v2 = 1'b0; bne2 = 1'b0; flush2 = 1'b0;
    rd2 = '0; rs1_2 = '0; rs2_2 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst2 = 1'b0;

    // reset state
    step(0, 0, 0, 0, 0, 0, 0);
    chk("rst_pend", obs_pend, 0);
    chk("rst_cnt", obs_cnt, 0);
    chk("rst_en", obs_en, 0);

    // single write rd=2, retires two cycles later
    step(1, 2, 3, 3, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("a_pend_n1", obs_pend[2], 1);
    chk("a_en_n1", obs_en, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("a_en_n2", obs_en, 4'b0100);
    chk("a_rd_n2", obs_rd, 2);
    chk("a_pend_n2", obs_pend[2], 1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("a_en_n3", obs_en, 0);
    chk("a_pend_n3", obs_pend[2], 0);

    // RAW stall, then retire bypass
    step(1, 1, 3, 3, 0, 0, 0);
    step(1, 3, 1, 3, 0, 0, 0);
    chk("b_stall", obs_ready, 0);
    step(1, 3, 1, 3, 0, 0, 0);
    chk("b_bypass", obs_ready, 1);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);

    // branch: no write, no slot count
    step(1, 0, 3, 3, 1, 0, 0);
    chk("c_ready", obs_ready, 1);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      chk("c_en", obs_en, 0);
      chk("c_cnt", obs_cnt, 0);
      chk("c_pend", obs_pend, 0);
    end

    // flush kills two in-flight writes
    step(1, 0, 3, 3, 0, 0, 0);
    step(1, 1, 3, 3, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("d_en_fl", obs_en, 0);
    chk("d_rdy_fl", obs_ready, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("d_en_1", obs_en, 0);
    chk("d_pend", obs_pend, 0);
    chk("d_cnt", obs_cnt, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("d_en_2", obs_en, 0);

    // register 0 write
    step(1, 0, 3, 3, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("e_pend0", obs_pend[0], ZL ? 0 : 1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("e_en0", obs_en, ZL ? 4'b0000 : 4'b0001);
    step(0, 0, 0, 0, 0, 0, 0);

    // reset with writes in flight
    step(1, 2, 3, 3, 0, 0, 0);
    step(1, 3, 1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("f_wbv_rst", obs_wbv, 0);
    chk("f_en_rst", obs_en, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("f_pend", obs_pend, 0);
    chk("f_en_1", obs_en, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("f_en_2", obs_en, 0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, NR - 1),
           $urandom_range(0, NR - 1),
           $urandom_range(0, NR - 1),
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 63) == 0);
    end
    step(0, 0, 0, 0, 0, 0, 0);

    // 8 registers, LAT=3: rd=7 retires three cycles after issue
    v2  = 1'b1;
    rd2 = 3'd7;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("r8_en", en2, (k == 3) ? 8'h80 : 8'h00);
      if (k == 0) chk("r8_rdy", rdy2, 1);
      if (k >= 1 && k <= 3) chk("r8_pend", pend2[7], 1);
      if (k == 4) chk("r8_pend_clr", pend2[7], 0);
      @(posedge clk);
      #1;
      v2 = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_write_ctrl.md
REG_WRITE_CTRL -- requirements
Module: reg_write_ctrl

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4: number of architectural registers, power of two, >=2.
REQ-002 SHALL have parameter LAT, default 2: write-back latency in cycles, >=1.
REQ-003 SHALL derive localparam AW = $clog2(NUM_REGS) and CW = $clog2(LAT+1).
REQ-004 clk  in  1  sole clock, all state on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 issue_valid  in  1  instruction offered for issue.
REQ-007 issue_ready  out  1  issue accepted this cycle when high with issue_valid.
REQ-008 issue_rd, issue_rs1, issue_rs2  in  AW each  destination and source register indices.
REQ-009 issue_bne  in  1  branch op; no register write.
REQ-010 flush  in  1  kill all in-flight writes.
REQ-011 reg_en  out  NUM_REGS  one-hot write-enable pulse, register i write at bit i.
REQ-012 wb_valid / wb_rd  out  1 / AW  write-back strobe and index, matching reg_en.
REQ-013 pending  out  NUM_REGS  scoreboard, bit i high while a write to i is in flight.
REQ-014 inflight_cnt  out  CW  number of valid pipeline entries.

Function
REQ-015 SHALL hold an LAT-stage shift pipeline of {valid, rd}, advancing every cycle, no back-pressure.
REQ-016 Accepted issue (issue_valid & issue_ready) SHALL load stage 0 with valid = ~issue_bne and rd = issue_rd.
REQ-017 Accepted issue at cycle N SHALL produce wb_valid high at cycle N+LAT for exactly one cycle, wb_rd = issued rd, reg_en = one-hot(rd).
REQ-018 When wb_valid is low, reg_en SHALL be all-zero and wb_rd SHALL be 0.
REQ-019 Accepted non-bne issue SHALL set pending[issue_rd]; write-back SHALL clear pending[wb_rd] in the same cycle reg_en pulses.
REQ-020 Hazard: busy = pending & ~(wb_valid ? onehot(wb_rd) : 0); issue_ready SHALL be low if busy[rd] (non-bne), busy[rs1] or busy[rs2], or flush is high; otherwise high.
REQ-021 Same-cycle retire and re-issue of one register SHALL be allowed; set SHALL win over clear.
REQ-022 bne issues SHALL check rs1/rs2 only, SHALL occupy a pipeline slot with valid=0, and SHALL never assert reg_en.
REQ-023 flush SHALL clear all stage valids, pending and inflight_cnt on the next edge and SHALL suppress reg_en/wb_valid in the flush cycle itself.
REQ-024 inflight_cnt SHALL equal the population count of stage valids, range 0..LAT.

Reset
REQ-025 With rst high at an edge, all stage valids, pending, and inflight_cnt SHALL become 0; reg_en/wb_valid SHALL be 0 during and after reset until a new write retires.
REQ-026 rst SHALL override flush and issue; in-flight writes at reset SHALL be dropped, never retired.

Configuration
REQ-027 Macro REG_WRITE_CTRL_ZERO_LOCK_EN, when defined: register 0 SHALL be hardwired -- issue with rd=0 SHALL enter as valid=0, never set pending[0], never pulse reg_en[0]; rs1/rs2=0 never stall.
REQ-028 Macro undefined: register 0 SHALL behave like every other register.

Structure
REQ-029 Shared package SHALL hold the one-hot decode function and the stage record typedef {valid, rd}; module SHALL import it.
REQ-030 One sub-module, reg_wb_pipe (LAT-deep valid/rd shift with flush), is natural; decode and scoreboard stay in reg_write_ctrl.

Verification
REQ-031 NUM_REGS=4, LAT=2: issue rd=2 at cycle 5 -> reg_en=4'b0100, wb_rd=2 at cycle 7 only; pending[2] high cycles 6-7, low cycle 8.
REQ-032 Issue rd=1 cycle 5, then rs1=1 cycle 6 -> issue_ready low cycle 6; high cycle 7 (retire bypass), accepted cycle 7.
REQ-033 Issue issue_bne=1, rs1=3 -> no reg_en pulse ever; inflight_cnt stays 0; pending unchanged.
REQ-034 Issue rd=0,1 cycles 5,6, flush cycle 7 -> no reg_en in cycles 7-9; pending=0, inflight_cnt=0 cycle 8.
REQ-035 With REG_WRITE_CTRL_ZERO_LOCK_EN: issue rd=0 -> no reg_en, pending[0]=0; undefined: reg_en=4'b0001 after LAT.
REQ-036 rst asserted cycle 6 with writes in flight -> pending=0, no reg_en pulse after; NUM_REGS=8, LAT=3 regression repeats REQ-031 with rd=7 -> reg_en=8'h80 at N+3.
